// File: rtl/mod10_wrap_tracker.sv
// Extends a mod-10 counter digit into a multi-digit BCD up/down count by detecting its
// 9<->0 wraps. It also keeps sticky status flags and reports each wrap on a valid/ready port.
module mod10_wrap_tracker #(
   parameter int unsigned DIGITS = 2
) (
   input  logic                    clock,
   input  logic                    rst,
   input  logic [3:0]              cnt_in,
   input  logic                    mode,
   input  logic                    load,
   input  logic                    clr_flags,
   input  logic                    evt_ready,
   output logic [4*(DIGITS+1)-1:0] bcd_out,
   output logic                    overflow,
   output logic                    underflow,
   output logic                    code_err,
   output logic                    evt_valid,
   output logic                    evt_dir,
   output logic                    evt_drop
);

   localparam int unsigned UW = 4 * DIGITS;

   logic [3:0]    cnt_q;
   logic          mode_q;
   logic          load_q;
   logic          hv_q;
   logic [UW-1:0] upper_q;
   logic [UW-1:0] upper_d;

   logic          up_wrap;
   logic          dn_wrap;
   logic          wrap;
   logic          carry;
   logic          borrow;
   logic          ovf_set;
   logic          unf_set;
   logic          err_set;
   logic          drop_set;
   logic          evt_valid_d;
   logic          evt_dir_d;

   // The cnt_q -> cnt_in step was caused by the controls the counter saw last edge.
   assign up_wrap = hv_q & mode_q & ~load_q & (cnt_q == 4'd9) & (cnt_in == 4'd0);
   assign dn_wrap = hv_q & ~mode_q & ~load_q & (cnt_q == 4'd0) & (cnt_in == 4'd9);
   assign wrap    = up_wrap | dn_wrap;
   assign err_set = (cnt_in > 4'd9);

   // Ripple BCD increment/decrement; a carry or borrow surviving every digit means all 9s/0s.
   always_comb begin
      upper_d = upper_q;
      carry   = up_wrap;
      borrow  = dn_wrap;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (upper_q[4*i +: 4] == 4'd9) begin
               upper_d[4*i +: 4] = 4'd0;
            end else begin
               upper_d[4*i +: 4] = upper_q[4*i +: 4] + 4'd1;
               carry             = 1'b0;
            end
         end
         if (borrow) begin
            if (upper_q[4*i +: 4] == 4'd0) begin
               upper_d[4*i +: 4] = 4'd9;
            end else begin
               upper_d[4*i +: 4] = upper_q[4*i +: 4] - 4'd1;
               borrow            = 1'b0;
            end
         end
      end
      ovf_set = carry;
      unf_set = borrow;
   end

   always_comb begin
      evt_valid_d = evt_valid;
      evt_dir_d   = evt_dir;
      drop_set    = 1'b0;
      if (wrap) begin
         if (!evt_valid || evt_ready) begin
            evt_valid_d = 1'b1;
            evt_dir_d   = up_wrap;
         end else begin
            drop_set = 1'b1;
         end
      end else if (evt_valid && evt_ready) begin
         evt_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         cnt_q     <= 4'd0;
         mode_q    <= 1'b0;
         load_q    <= 1'b0;
         hv_q      <= 1'b0;
         upper_q   <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         code_err  <= 1'b0;
         evt_valid <= 1'b0;
         evt_dir   <= 1'b0;
         evt_drop  <= 1'b0;
      end else begin
         cnt_q     <= cnt_in;
         mode_q    <= mode;
         load_q    <= load;
         hv_q      <= 1'b1;
         upper_q   <= upper_d;
         overflow  <= ovf_set | (overflow & ~clr_flags);
         underflow <= unf_set | (underflow & ~clr_flags);
         code_err  <= err_set | (code_err & ~clr_flags);
         evt_drop  <= drop_set | (evt_drop & ~clr_flags);
         evt_valid <= evt_valid_d;
         evt_dir   <= evt_dir_d;
      end
   end

   assign bcd_out = {upper_q, cnt_q};

endmodule
